axi_lite_mem_slave: RTL and testbench

//  AXI4-Lite responder backing the MMU's memory-side master port (m_axi_*): word-wide RAM with byte strobes.

---
 rtl/axi_lite_mem_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite word RAM responder with byte strobes, one outstanding transaction, OKAY/SLVERR by address range.
// Optional handshake stress (LFSR-driven ready/valid stalls) is built when AXI_MEM_STALL_EN is defined.
module axi_lite_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [29:0] BASE_WORD   = BASE_ADDR[31:2];
  localparam logic [2:0]  CNT_INIT    = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_WAIT    = 3'd1,
    S_RD_RESP    = 3'd2,
    S_WR_NEED_W  = 3'd3,
    S_WR_NEED_AW = 3'd4,
    S_WR_EXEC    = 3'd5,
    S_WR_RESP    = 3'd6
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  state_t      r_state;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rvalid;
  logic [1:0]  r_bresp;
  logic        r_bvalid;
  logic [31:0] r_mem [0:DEPTH-1];

  logic [29:0]      w_off;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_word;
  logic             w_idle;
  logic             w_arready;
  logic             w_awready;
  logic             w_wready;
  logic             w_ar_hs;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_stall_rdy;
  logic             w_stall_rsp;
  logic             w_unused_addr_lsbs;

  // Byte-address bits [1:0] carry no information for a word-wide RAM.
  assign w_unused_addr_lsbs = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};

  // Word-granular offset: unsigned wrap makes addresses below the base land out of range.
  assign w_off      = r_addr - BASE_WORD;
  assign w_in_range = ((w_off >> IDX_W) == 30'd0);
  assign w_idx      = w_off[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];

`ifdef AXI_MEM_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) choosing stall cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall_rdy = r_lfsr[0];
  assign w_stall_rsp = r_lfsr[1];
`else
  assign w_stall_rdy = 1'b0;
  assign w_stall_rsp = 1'b0;
`endif

  // Read has priority in IDLE: a simultaneous write sees no ready until the read retires.
  assign w_idle    = (r_state == S_IDLE);
  assign w_arready = rstn & ~w_stall_rdy & w_idle;
  assign w_awready = rstn & ~w_stall_rdy & ((w_idle & ~s_axi_arvalid) | (r_state == S_WR_NEED_AW));
  assign w_wready  = rstn & ~w_stall_rdy & ((w_idle & ~s_axi_arvalid) | (r_state == S_WR_NEED_W));

  assign w_ar_hs = s_axi_arvalid & w_arready;
  assign w_aw_hs = s_axi_awvalid & w_awready;
  assign w_w_hs  = s_axi_wvalid  & w_wready;

  assign s_axi_arready = w_arready;
  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = r_bvalid;

  // RAM write port; held off during reset so a dropped write never lands.
  always_ff @(posedge clk) begin
    if (rstn && (r_state == S_WR_EXEC) && w_in_range) begin
      r_mem[w_idx] <= merge_bytes(w_rd_word, r_wdata, r_wstrb);
    end
  end

  // Transaction FSM with registered R and B channel outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_addr   <= 30'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_cnt    <= 3'd0;
      r_rdata  <= 32'd0;
      r_rresp  <= RESP_OKAY;
      r_rvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_bvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_addr  <= s_axi_araddr[31:2];
            r_cnt   <= CNT_INIT;
            r_state <= S_RD_WAIT;
          end else if (w_aw_hs && w_w_hs) begin
            r_addr  <= s_axi_awaddr[31:2];
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
            r_state <= S_WR_EXEC;
          end else if (w_aw_hs) begin
            r_addr  <= s_axi_awaddr[31:2];
            r_state <= S_WR_NEED_W;
          end else if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
            r_state <= S_WR_NEED_AW;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else if (!w_stall_rsp) begin
            r_rdata  <= w_in_range ? w_rd_word : 32'd0;
            r_rresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            r_rvalid <= 1'b1;
            r_state  <= S_RD_RESP;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_RESP: begin
          if (s_axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_RD_RESP;
          end
        end
        S_WR_NEED_W: begin
          if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
            r_state <= S_WR_EXEC;
          end else begin
            r_state <= S_WR_NEED_W;
          end
        end
        S_WR_NEED_AW: begin
          if (w_aw_hs) begin
            r_addr  <= s_axi_awaddr[31:2];
            r_state <= S_WR_EXEC;
          end else begin
            r_state <= S_WR_NEED_AW;
          end
        end
        S_WR_EXEC: begin
          // A stalled EXEC rewrites the same merged word, which is idempotent.
          if (!w_stall_rsp) begin
            r_bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_state  <= S_WR_RESP;
          end else begin
            r_state <= S_WR_EXEC;
          end
        end
        S_WR_RESP: begin
          if (s_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_WR_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: directed corner cases plus randomized reads/writes
// checked against an associative-array memory model; a monitor compares every R/B beat.
module tb_axi_lite_mem_slave;

  localparam int          AW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          RL   = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] araddr = 32'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = 32'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_lite_mem_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RD_LATENCY(RL)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic [1:0] resp; int cyc; } rexp_t;
  typedef struct { logic [1:0] resp; int cyc; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model [int];
  int          checks = 0;
  int          errors = 0;
  int          last_r_done = 0;
  bit          hold_r = 1'b0;
  bit          hold_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference model: plain address arithmetic on a sparse word array.
  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned off;
    off = longint'(32'(a - BASE));
    return off < (64'd1 << AW);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(32'(a - BASE) / 32'd4);
  endfunction

  function automatic rexp_t exp_read(input logic [31:0] a);
    rexp_t e;
    e.cyc = 0;
    if (in_rng(a)) begin
      e.data = model.exists(widx(a)) ? model[widx(a)] : 32'd0;
      e.resp = 2'b00;
    end else begin
      e.data = 32'd0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!in_rng(a)) return 2'b10;
    w = model.exists(widx(a)) ? model[widx(a)] : 32'd0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[widx(a)] = w;
    return 2'b00;
  endfunction

  task automatic do_read(input logic [31:0] a);
    rexp_t e;
    bit    done = 1'b0;
    int    t = 0;
    e = exp_read(a);
    araddr  = a;
    arvalid = 1'b1;
    while (!done && t < 300) begin
      @(negedge clk);
      if (arready) begin done = 1'b1; e.cyc = cyc; end
      @(posedge clk); #1;
      t++;
    end
    arvalid = 1'b0;
    araddr  = $urandom;
    if (done) rq.push_back(e);
    else timeout("ar_handshake");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int aw_lead, output int hs_cyc);
    bexp_t e;
    bit    aw_done = 1'b0;
    bit    w_done = 1'b0;
    int    t = 0;
    hs_cyc = 0;
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    while (!(aw_done && w_done) && t < 300) begin
      awvalid = !aw_done && (t >= aw_lead);
      wvalid  = !w_done && (t >= w_lead);
      @(negedge clk);
      if (awvalid && awready) begin aw_done = 1'b1; hs_cyc = cyc; end
      if (wvalid && wready) begin w_done = 1'b1; hs_cyc = cyc; end
      @(posedge clk); #1;
      t++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (aw_done && w_done) begin
      e.resp = model_write(a, d, s);
      e.cyc  = hs_cyc;
      bq.push_back(e);
    end else begin
      timeout("aw_w_handshake");
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 400) timeout("drain");
  endtask

  // Response driver: random back-pressure unless a directed test holds it low.
  initial begin
    forever begin
      @(posedge clk); #1;
      rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
      bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares each presented R/B beat with the scoreboard head, pops on handshake.
  initial begin
    bit prv = 1'b0;
    bit pbv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prv = 1'b0;
        pbv = 1'b0;
      end else begin
        if (rvalid) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected actual rvalid=1 required=no pending read (cycle %0d)", cyc);
          end else begin
            chk("rdata", rdata, rq[0].data);
            chk("rresp", {30'd0, rresp}, {30'd0, rq[0].resp});
`ifndef AXI_MEM_STALL_EN
            if (!prv) chk("r_latency", cyc, rq[0].cyc + 1 + RL);
`endif
            if (rready) begin
              void'(rq.pop_front());
              last_r_done = cyc;
            end
          end
        end
        if (bvalid) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected actual bvalid=1 required=no pending write (cycle %0d)", cyc);
          end else begin
            chk("bresp", {30'd0, bresp}, {30'd0, bq[0].resp});
`ifndef AXI_MEM_STALL_EN
            if (!pbv) chk("b_latency", cyc, bq[0].cyc + 2);
`endif
            if (bready) void'(bq.pop_front());
          end
        end
        prv = rvalid;
        pbv = bvalid;
      end
    end
  end

  initial begin
    int          hs;
    int          t;
    logic [31:0] pool [$];
    logic [31:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", {30'd0, rresp}, 32'd0);
    chk("rst_bresp", {30'd0, bresp}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full write then read, byte-lane merge, out-of-range, W-before-AW
    do_write(32'h0000_0100, 32'hDEADBEEF, 4'hF, 0, 0, hs);
    do_read(32'h0000_0100);
    do_write(32'h0000_0100, 32'h11223344, 4'b0010, 0, 0, hs);
    do_read(32'h0000_0102);
    do_write(32'h0000_0000, 32'hCAFEF00D, 4'hF, 0, 0, hs);
    do_read(32'h0001_0000);
    do_write(32'h0001_0000, 32'h12345678, 4'hF, 0, 0, hs);
    do_read(32'h0000_0000);
    do_write(32'hFFFF_FFFC, 32'h87654321, 4'hF, 1, 0, hs);
    do_read(32'hFFFF_FFFC);
    do_write(32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 0, 0, hs);
    do_read(32'h0000_0100);
    do_write(32'h0000_0008, 32'h5A5A5A5A, 4'hF, 0, 3, hs);
    do_read(32'h0000_0008);
    drain();

    // Simultaneous AR and AW/W: read goes first, write waits for IDLE
    araddr  = 32'h0000_0100;
    arvalid = 1'b1;
    awaddr  = 32'h0000_0104;
    awvalid = 1'b1;
    wdata   = 32'hA5A5_0001;
    wstrb   = 4'hF;
    wvalid  = 1'b1;
    begin
      rexp_t e;
      e = exp_read(32'h0000_0100);
      @(negedge clk);
      chk("t5_arready", {31'd0, arready}, 32'd1);
      chk("t5_awready", {31'd0, awready}, 32'd0);
      chk("t5_wready", {31'd0, wready}, 32'd0);
      e.cyc = cyc;
      @(posedge clk); #1;
      arvalid = 1'b0;
      rq.push_back(e);
    end
    do_write(32'h0000_0104, 32'hA5A5_0001, 4'hF, 0, 0, hs);
    chk("t5_write_after_read", {31'd0, (hs > last_r_done)}, 32'd1);
    drain();
    do_read(32'h0000_0104);
    drain();

    // rready held low: response must stay put for 5 cycles
    hold_r = 1'b1;
    do_read(32'h0000_0100);
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    if (!rvalid) timeout("t6_rvalid");
    repeat (5) begin
      @(negedge clk);
      chk("t6_rvalid_held", {31'd0, rvalid}, 32'd1);
    end
    @(posedge clk); #1;
    hold_r = 1'b0;
    drain();

    // Reset pulsed while a write response is pending
    hold_b = 1'b1;
    do_write(32'h0000_0200, 32'h0BADC0DE, 4'hF, 0, 0, hs);
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    if (!bvalid) timeout("t6_bvalid");
    @(posedge clk); #1;
    rstn = 1'b0;
    bq.delete();
    @(negedge clk);
    chk("t6_rst_awready", {31'd0, awready}, 32'd0);
    chk("t6_rst_wready", {31'd0, wready}, 32'd0);
    @(negedge clk);
    chk("t6_rst_bvalid", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
    rstn   = 1'b1;
    hold_b = 1'b0;
    do_read(32'h0000_0200);
    drain();

    // Randomized traffic over a small address pool
    for (int i = 0; i < 16; i++) pool.push_back(BASE + 32'(i * 4));
    pool.push_back(32'h0000_FFFC);
    foreach (pool[i]) do_write(pool[i], $urandom, 4'hF, 0, 0, hs);
    pool.push_back(32'h0001_0000);
    pool.push_back(32'hFFFF_FFFC);
    pool.push_back(32'h8000_0000);
    for (int i = 0; i < 80; i++) begin
      a = pool[$urandom_range(0, pool.size() - 1)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) do_read(a);
      else do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), hs);
    end
    drain();
    chk("final_rq_empty", rq.size(), 32'd0);
    chk("final_bq_empty", bq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
